// File: rtl/ecsu_pkg.sv
// Shared types and encodings for the multi-station weather alert controller.
package ecsu_pkg;

  typedef logic [1:0] ecsu_state_t;

  localparam logic [1:0] ST_ALL_CLEAR  = 2'b00;
  localparam logic [1:0] ST_CAUTION    = 2'b01;
  localparam logic [1:0] ST_HIGH_ALERT = 2'b10;
  localparam logic [1:0] ST_EMERGENCY  = 2'b11;

  localparam logic [1:0] VIS_CLEAR   = 2'b00;
  localparam logic [1:0] VIS_REDUCED = 2'b01;
  localparam logic [1:0] VIS_ZERO    = 2'b11;

endpackage

// File: rtl/ecsu_channel.sv
// One weather channel: four-level alert FSM with de-escalation persistence
// counter and the emergency flag from the most recent valid sample.
//
// state        | meaning
// ALL_CLEAR 00 | no hazard
// CAUTION   01 | moderate wind with reduced visibility
// HIGH_ALERT 10| storm, high wind, zero visibility or temperature extreme
// EMERGENCY 11 | severe wind/temperature; left only by operator ack
module ecsu_channel
  import ecsu_pkg::*;
#(
  parameter int WIND_W     = 6,
  parameter int TEMP_W     = 8,
  parameter int PERSIST    = 3,
  parameter int WIND_CAUT  = 10,
  parameter int WIND_HIGH  = 15,
  parameter int WIND_EMERG = 20,
  parameter int TEMP_HIGH  = 35,
  parameter int TEMP_EMERG = 40
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     sample_valid_i,
  input  logic                     storm_i,
  input  logic [WIND_W-1:0]        wind_i,
  input  logic [1:0]               vis_i,
  input  logic signed [TEMP_W-1:0] temp_i,
  input  logic                     ack_i,
  output ecsu_state_t              state_o,
  output logic                     severe_o,
  output logic                     alert_o
);

  localparam int CNT_W = (PERSIST < 1) ? 1 : $clog2(PERSIST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERSIST - 1);

  ecsu_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             em_q, em_d;
  logic             severe_q, alert_q;

  int   wind_v, temp_v;
  logic hi, em, caut, clr, rlx, em_latest;

  assign wind_v = int'(wind_i);
  assign temp_v = int'(temp_i);

  assign em   = (wind_v > WIND_EMERG) || (temp_v > TEMP_EMERG) || (temp_v < -TEMP_EMERG);
  assign hi   = storm_i || (wind_v > WIND_HIGH) || (vis_i == VIS_ZERO) ||
                (temp_v > TEMP_HIGH) || (temp_v < -TEMP_HIGH);
  assign caut = (wind_v > WIND_CAUT) && (wind_v <= WIND_HIGH) && (vis_i == VIS_REDUCED);
  assign clr  = (wind_v <= WIND_CAUT) && (vis_i == VIS_CLEAR) && !hi;
  assign rlx  = !hi && (wind_v <= WIND_CAUT) && (vis_i == VIS_REDUCED);

  assign em_latest = sample_valid_i ? em : em_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    em_d    = sample_valid_i ? em : em_q;
    case (state_q)
      ST_ALL_CLEAR: begin
        cnt_d = '0;
        if (sample_valid_i) begin
          if (hi || em)  state_d = ST_HIGH_ALERT;
          else if (caut) state_d = ST_CAUTION;
        end
      end
      ST_CAUTION: begin
        if (sample_valid_i) begin
          if (hi) state_d = ST_HIGH_ALERT;
          else if (clr) begin
            if (cnt_q == CNT_LAST) state_d = ST_ALL_CLEAR;
            else                   cnt_d   = cnt_q + 1'b1;
          end else cnt_d = '0;
        end
      end
      ST_HIGH_ALERT: begin
        if (sample_valid_i) begin
          if (em) state_d = ST_EMERGENCY;
          else if (rlx) begin
            if (cnt_q == CNT_LAST) state_d = ST_CAUTION;
            else                   cnt_d   = cnt_q + 1'b1;
          end else cnt_d = '0;
        end
      end
      default: begin
        cnt_d = '0;
        if (ack_i && !em_latest) state_d = ST_HIGH_ALERT;
      end
    endcase
    // Any level change restarts the de-escalation qualification.
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_ALL_CLEAR;
      cnt_q    <= '0;
      em_q     <= 1'b0;
      severe_q <= 1'b0;
      alert_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      em_q     <= em_d;
      severe_q <= state_d[1];
      alert_q  <= (state_d == ST_EMERGENCY);
    end
  end

  assign state_o  = state_q;
  assign severe_o = severe_q;
  assign alert_o  = alert_q;

endmodule

// File: rtl/ecsu_multi.sv
// Tower-level weather alert controller: N_CH independent channels plus
// worst-state and any-emergency summaries.
module ecsu_multi
  import ecsu_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int WIND_W     = 6,
  parameter int TEMP_W     = 8,
  parameter int PERSIST    = 3,
  parameter int WIND_CAUT  = 10,
  parameter int WIND_HIGH  = 15,
  parameter int WIND_EMERG = 20,
  parameter int TEMP_HIGH  = 35,
  parameter int TEMP_EMERG = 40
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     sample_valid,
  input  logic [N_CH-1:0]          thunderstorm,
  input  logic [N_CH*WIND_W-1:0]   wind,
  input  logic [N_CH*2-1:0]        visibility,
  input  logic [N_CH*TEMP_W-1:0]   temperature,
  input  logic [N_CH-1:0]          emerg_ack,
  output logic [N_CH*2-1:0]        ch_state,
  output logic [N_CH-1:0]          severe_weather,
  output logic [N_CH-1:0]          emergency_landing_alert,
  output logic [1:0]               worst_state,
  output logic                     any_emergency
);

  ecsu_state_t st_w [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ecsu_channel #(
      .WIND_W    (WIND_W),
      .TEMP_W    (TEMP_W),
      .PERSIST   (PERSIST),
      .WIND_CAUT (WIND_CAUT),
      .WIND_HIGH (WIND_HIGH),
      .WIND_EMERG(WIND_EMERG),
      .TEMP_HIGH (TEMP_HIGH),
      .TEMP_EMERG(TEMP_EMERG)
    ) u_ch (
      .CLK           (CLK),
      .RST           (RST),
      .sample_valid_i(sample_valid),
      .storm_i       (thunderstorm[i]),
      .wind_i        (wind[i*WIND_W +: WIND_W]),
      .vis_i         (visibility[i*2 +: 2]),
      .temp_i        (temperature[i*TEMP_W +: TEMP_W]),
      .ack_i         (emerg_ack[i]),
      .state_o       (st_w[i]),
      .severe_o      (severe_weather[i]),
      .alert_o       (emergency_landing_alert[i])
    );
    assign ch_state[i*2 +: 2] = st_w[i];
  end

  always_comb begin
    worst_state = ST_ALL_CLEAR;
    for (int i = 0; i < N_CH; i++) begin
      if (st_w[i] > worst_state) worst_state = st_w[i];
    end
  end

  assign any_emergency = |emergency_landing_alert;

endmodule

// File: tb/tb_ecsu_multi.sv
// Directed scoreboard bench for ecsu_multi: the driver queues hand-computed
// per-channel states, a negedge monitor pops and compares them.
module tb_ecsu_multi;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        sample_valid = 1'b0;
  logic [3:0]  thunderstorm = '0;
  logic [23:0] wind = '0;
  logic [7:0]  visibility = '0;
  logic [31:0] temperature = '0;
  logic [3:0]  emerg_ack = '0;
  logic [7:0]  ch_state;
  logic [3:0]  severe_weather;
  logic [3:0]  emergency_landing_alert;
  logic [1:0]  worst_state;
  logic        any_emergency;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] st;
    string      nm;
  } exp_t;
  exp_t sbq[$];

  int         ws[4];
  int         ts[4];
  logic [1:0] vs[4];
  logic [3:0] storm_s, ack_s;
  logic       valid_s, rst_s;

  always #5 CLK = ~CLK;

  ecsu_multi #(
    .N_CH(4), .WIND_W(6), .TEMP_W(8), .PERSIST(3), .WIND_CAUT(10),
    .WIND_HIGH(15), .WIND_EMERG(20), .TEMP_HIGH(35), .TEMP_EMERG(40)
  ) dut (
    .CLK(CLK), .RST(RST), .sample_valid(sample_valid),
    .thunderstorm(thunderstorm), .wind(wind), .visibility(visibility),
    .temperature(temperature), .emerg_ack(emerg_ack),
    .ch_state(ch_state), .severe_weather(severe_weather),
    .emergency_landing_alert(emergency_landing_alert),
    .worst_state(worst_state), .any_emergency(any_emergency)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0] st);
    logic [3:0] sev, alr;
    logic [1:0] worst;
    worst = 2'b00;
    for (int i = 0; i < 4; i++) begin
      sev[i] = st[i*2+1];
      alr[i] = &st[i*2 +: 2];
      if (st[i*2 +: 2] > worst) worst = st[i*2 +: 2];
    end
    chk({nm, ".ch_state"}, 32'(ch_state), 32'(st));
    chk({nm, ".severe"},   32'(severe_weather), 32'(sev));
    chk({nm, ".alert"},    32'(emergency_landing_alert), 32'(alr));
    chk({nm, ".worst"},    32'(worst_state), 32'(worst));
    chk({nm, ".any_emerg"}, 32'(any_emergency), 32'(|alr));
  endtask

  always @(negedge CLK) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk_all(e.nm, e.st);
    end
  end

  task automatic calm();
    for (int i = 0; i < 4; i++) begin
      ws[i] = 0; ts[i] = 20; vs[i] = 2'b00;
    end
    storm_s = '0; ack_s = '0; valid_s = 1'b1;
  endtask

  // Apply staged inputs for one clock and queue the state expected after it.
  task automatic step(input logic [7:0] exp_st, input string nm);
    exp_t e;
    @(negedge CLK);
    #1;
    RST          = rst_s;
    sample_valid = valid_s;
    thunderstorm = storm_s;
    emerg_ack    = ack_s;
    for (int i = 0; i < 4; i++) begin
      wind[i*6 +: 6]        = ws[i][5:0];
      visibility[i*2 +: 2]  = vs[i];
      temperature[i*8 +: 8] = ts[i][7:0];
    end
    e.st = exp_st;
    e.nm = nm;
    sbq.push_back(e);
  endtask

  initial begin
    calm();
    storm_s = 4'hF;
    for (int i = 0; i < 4; i++) begin ws[i] = 30; ts[i] = -50; end
    rst_s = 1'b1;
    #2 RST = 1'b1;
    #1 chk_all("async_reset", 8'h00);
    step(8'b00_00_00_00, "rst_hold0");
    step(8'b00_00_00_00, "rst_hold1");

    calm(); rst_s = 1'b0;
    step(8'b00_00_00_00, "release");

    // ch0 caution then persistence with a restart
    ws[0] = 12; vs[0] = 2'b01; step(8'b00_00_00_01, "ch0_caut");
    ws[0] = 5;  vs[0] = 2'b00; step(8'b00_00_00_01, "ch0_clr1");
    step(8'b00_00_00_01, "ch0_clr2");
    ws[0] = 12; vs[0] = 2'b01; step(8'b00_00_00_01, "ch0_restart");
    ws[0] = 5;  vs[0] = 2'b00; step(8'b00_00_00_01, "ch0_clr1b");
    step(8'b00_00_00_01, "ch0_clr2b");
    step(8'b00_00_00_00, "ch0_clr3b");

    // ch1 storm, emergency, ack handshake
    storm_s = 4'b0010; step(8'b00_00_10_00, "ch1_storm");
    storm_s = 4'b0000; ts[1] = 41; step(8'b00_00_11_00, "ch1_emerg");
    ack_s = 4'b0010; step(8'b00_00_11_00, "ch1_ack_em");
    ts[1] = 20; step(8'b00_00_10_00, "ch1_ack_ok");
    ack_s = 4'b0000; ts[1] = 41; step(8'b00_00_11_00, "ch1_emerg2");
    valid_s = 1'b0; ts[1] = 20; ack_s = 4'b0010; step(8'b00_00_11_00, "ch1_ack_stored_em");
    valid_s = 1'b1; ack_s = 4'b0000; step(8'b00_00_11_00, "ch1_no_ack");
    valid_s = 1'b0; ack_s = 4'b0010; step(8'b00_00_10_00, "ch1_ack_stored_ok");
    valid_s = 1'b1; ack_s = 4'b0000; step(8'b00_00_10_00, "ch1_hold_high");

    // thresholds
    ws[3] = 15; vs[3] = 2'b01; ws[0] = 16;
    step(8'b01_00_10_10, "wind15_wind16");
    ws[3] = 0; vs[3] = 2'b00; ts[2] = -35; ws[0] = 20;
    step(8'b01_00_10_10, "tempm35_wind20");
    ts[2] = -36; ws[0] = 21;
    step(8'b01_10_10_11, "tempm36_wind21");
    ts[2] = 20; ws[0] = 0;
    step(8'b00_10_10_11, "ch3_clear");

    // ch1 relax with gaps, ch3 storm on the qualifying cycle
    ws[1] = 5; vs[1] = 2'b01;
    step(8'b00_10_10_11, "rlx1");
    valid_s = 1'b0; step(8'b00_10_10_11, "gap1");
    step(8'b00_10_10_11, "gap2");
    valid_s = 1'b1; step(8'b00_10_10_11, "rlx2");
    valid_s = 1'b0; step(8'b00_10_10_11, "gap3");
    valid_s = 1'b1; storm_s = 4'b1000;
    step(8'b10_10_01_11, "rlx3_storm3");
    storm_s = 4'b0000; ts[2] = 45;
    step(8'b10_11_01_11, "ch2_emerg");

    // asynchronous reset between edges with ch0 and ch2 in EMERGENCY
    @(negedge CLK);
    #2;
    rst_s = 1'b1; RST = 1'b1;
    #1 chk_all("mid_async_reset", 8'h00);
    storm_s = 4'hF; ts[0] = 45;
    step(8'b00_00_00_00, "mid_rst_hold0");
    step(8'b00_00_00_00, "mid_rst_hold1");
    rst_s = 1'b0; valid_s = 1'b0;
    step(8'b00_00_00_00, "post_rst_novalid");
    valid_s = 1'b1; storm_s = 4'b0000; ts[0] = 20;
    step(8'b00_10_00_00, "post_rst_em_to_high");

    for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge CLK);
    #1;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
